// File: rtl/vx_lane_accumulate.sv
// vx_lane_accumulate: multi-lane windowed accumulator with handshakes, saturation and flush
module vx_lane_accumulate #(
  parameter int DATAW    = 8,
  parameter int ACCW     = 16,
  parameter int LANES    = 4,
  parameter int MAXN     = 16,
  parameter int SIGNED   = 1,
  parameter int SATURATE = 1,
  parameter int CNTW     = $clog2(MAXN) + 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [CNTW-1:0]         len_cfg,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES*DATAW-1:0]  in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANES*ACCW-1:0]   out_data,
  output logic [LANES-1:0]        out_ovf,
  output logic                    busy
);
  logic [CNTW-1:0]       cnt, len_q, len_eff;
  logic [LANES*ACCW-1:0] acc, nxt_acc;
  logic [LANES-1:0]      ovf, nxt_ovf;
  logic                  fire, first, last;
  assign in_ready = ~reset & ~flush & (~out_valid | out_ready);
  assign fire     = in_valid & in_ready;
  assign first    = cnt == '0;
  assign busy     = ~first;
  // len_cfg only matters on the first beat; afterwards the latched length rules
  assign len_eff  = !first ? len_q :
                    len_cfg == '0 ? CNTW'(1) :
                    len_cfg > CNTW'(MAXN) ? CNTW'(MAXN) : len_cfg;
  assign last     = fire & (cnt + CNTW'(1) == len_eff);
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [DATAW-1:0] d;
    logic [ACCW-1:0]  a, ext, sum, clamp;
    logic             o;
    assign d   = in_data[i*DATAW +: DATAW];
    assign a   = acc[i*ACCW +: ACCW];
    assign sum = a + ext;
    if (SIGNED != 0) begin : g_s
      assign ext   = {{(ACCW-DATAW+1){d[DATAW-1]}}, d[DATAW-2:0]};
      assign o     = a[ACCW-1] == ext[ACCW-1] && sum[ACCW-1] != a[ACCW-1];
      assign clamp = {a[ACCW-1], {(ACCW-1){~a[ACCW-1]}}};
    end else begin : g_u
      assign ext   = ACCW'(d);
      assign o     = sum < a;
      assign clamp = '1;
    end
    assign nxt_acc[i*ACCW +: ACCW] = first ? ext : (o && SATURATE != 0) ? clamp : sum;
    assign nxt_ovf[i]              = ~first & (ovf[i] | o);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt       <= '0;
      len_q     <= '0;
      acc       <= '0;
      ovf       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ovf   <= '0;
    end else begin
      if (flush) begin
        cnt <= '0;
        acc <= '0;
        ovf <= '0;
      end else if (fire) begin
        cnt <= last ? '0 : cnt + CNTW'(1);
        acc <= nxt_acc;
        ovf <= nxt_ovf;
        if (first) len_q <= len_eff;
      end
      if (last) begin
        out_valid <= 1'b1;
        out_data  <= nxt_acc;
        out_ovf   <= nxt_ovf;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_vx_lane_accumulate.sv
// tb_vx_lane_accumulate: directed checks of windowing, handshake, saturation, flush and reset
module tb_vx_lane_accumulate;
  logic        clk = 0, reset = 1, flush = 0, in_valid = 0, out_ready = 1;
  logic [4:0]  len_cfg = 5'd4;
  logic [31:0] din = '0;
  logic        m_in_ready, m_out_valid, m_busy;
  logic [63:0] m_out_data;
  logic [3:0]  m_out_ovf;
  logic        s_in_ready, s_out_valid, s_busy, w_in_ready, w_out_valid, w_busy;
  logic        u_in_ready, u_out_valid, u_busy;
  logic [31:0] s_out_data, w_out_data, u_out_data;
  logic [3:0]  s_out_ovf, w_out_ovf, u_out_ovf;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  vx_lane_accumulate #(.SIGNED(0)) u_main (.clk(clk), .reset(reset), .len_cfg(len_cfg),
    .flush(flush), .in_valid(in_valid), .in_ready(m_in_ready), .in_data(din),
    .out_valid(m_out_valid), .out_ready(out_ready), .out_data(m_out_data),
    .out_ovf(m_out_ovf), .busy(m_busy));
  vx_lane_accumulate #(.ACCW(8)) u_sat (.clk(clk), .reset(reset), .len_cfg(len_cfg),
    .flush(flush), .in_valid(in_valid), .in_ready(s_in_ready), .in_data(din),
    .out_valid(s_out_valid), .out_ready(out_ready), .out_data(s_out_data),
    .out_ovf(s_out_ovf), .busy(s_busy));
  vx_lane_accumulate #(.ACCW(8), .SATURATE(0)) u_wrap (.clk(clk), .reset(reset), .len_cfg(len_cfg),
    .flush(flush), .in_valid(in_valid), .in_ready(w_in_ready), .in_data(din),
    .out_valid(w_out_valid), .out_ready(out_ready), .out_data(w_out_data),
    .out_ovf(w_out_ovf), .busy(w_busy));
  vx_lane_accumulate #(.ACCW(8), .SIGNED(0)) u_usat (.clk(clk), .reset(reset), .len_cfg(len_cfg),
    .flush(flush), .in_valid(in_valid), .in_ready(u_in_ready), .in_data(din),
    .out_valid(u_out_valid), .out_ready(out_ready), .out_data(u_out_data),
    .out_ovf(u_out_ovf), .busy(u_busy));
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset;
    reset = 1;
    tick;
    tick;
    total += 5;
    if (m_out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", m_out_valid); end
    if (m_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", m_busy); end
    if (m_in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready got=%b want=0", m_in_ready); end
    if (m_out_data !== 64'd0) begin bad++; $display("FAIL reset_data got=%h want=0", m_out_data); end
    if (m_out_ovf !== 4'd0) begin bad++; $display("FAIL reset_ovf got=%b want=0", m_out_ovf); end
    reset = 0;
  endtask
  task automatic test_window;
    len_cfg = 5'd4;
    out_ready = 1;
    for (int k = 1; k <= 4; k++) begin
      din = {8'd0, 8'd255, 8'(10 * k), 8'(k)};
      in_valid = 1;
      tick;
      if (k == 2) begin
        in_valid = 0;
        tick;
        total += 2;
        if (m_busy !== 1'b1) begin bad++; $display("FAIL idle_busy got=%b want=1", m_busy); end
        if (m_out_valid !== 1'b0) begin bad++; $display("FAIL idle_valid got=%b want=0", m_out_valid); end
      end
    end
    in_valid = 0;
    total += 3;
    if (m_out_valid !== 1'b1) begin bad++; $display("FAIL win_valid got=%b want=1", m_out_valid); end
    if (m_out_data !== {16'd0, 16'd1020, 16'd100, 16'd10})
      begin bad++; $display("FAIL win_data got=%h want=%h", m_out_data, {16'd0, 16'd1020, 16'd100, 16'd10}); end
    if (m_busy !== 1'b0) begin bad++; $display("FAIL win_busy got=%b want=0", m_busy); end
    tick;
    total++;
    if (m_out_valid !== 1'b0) begin bad++; $display("FAIL win_one_cycle got=%b want=0", m_out_valid); end
  endtask
  task automatic test_signed;
    logic [31:0] beats [3];
    beats[0] = {8'd0, 8'd200, 8'h9C, 8'd100};
    beats[1] = {8'd0, 8'd100, 8'h9C, 8'd100};
    beats[2] = {8'd0, 8'd1, 8'h05, 8'hFB};
    len_cfg = 5'd3;
    for (int k = 0; k < 3; k++) begin
      din = beats[k];
      in_valid = 1;
      tick;
    end
    in_valid = 0;
    total += 8;
    if (s_out_data !== 32'h002D857A) begin bad++; $display("FAIL sat_data got=%h want=002d857a", s_out_data); end
    if (s_out_ovf !== 4'b0011) begin bad++; $display("FAIL sat_ovf got=%b want=0011", s_out_ovf); end
    if (w_out_data !== 32'h002D3DC3) begin bad++; $display("FAIL wrap_data got=%h want=002d3dc3", w_out_data); end
    if (w_out_ovf !== 4'b0011) begin bad++; $display("FAIL wrap_ovf got=%b want=0011", w_out_ovf); end
    if (u_out_data !== 32'h00FFFFFF) begin bad++; $display("FAIL usat_data got=%h want=00ffffff", u_out_data); end
    if (u_out_ovf !== 4'b0111) begin bad++; $display("FAIL usat_ovf got=%b want=0111", u_out_ovf); end
    if (m_out_data !== {16'd0, 16'd301, 16'd317, 16'd451})
      begin bad++; $display("FAIL uns_data got=%h want=%h", m_out_data, {16'd0, 16'd301, 16'd317, 16'd451}); end
    if (m_out_ovf !== 4'b0000) begin bad++; $display("FAIL uns_ovf got=%b want=0000", m_out_ovf); end
    tick;
  endtask
  task automatic test_backpressure;
    len_cfg = 5'd2;
    out_ready = 1;
    din = 32'd1;
    in_valid = 1;
    tick;
    out_ready = 0;
    din = 32'd2;
    tick;
    din = 32'd3;
    total += 3;
    if (m_in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready got=%b want=0", m_in_ready); end
    if (m_out_valid !== 1'b1) begin bad++; $display("FAIL bp_valid got=%b want=1", m_out_valid); end
    if (m_out_data[15:0] !== 16'd3) begin bad++; $display("FAIL bp_first got=%0d want=3", m_out_data[15:0]); end
    tick;
    tick;
    total += 3;
    if (m_out_valid !== 1'b1) begin bad++; $display("FAIL bp_hold_valid got=%b want=1", m_out_valid); end
    if (m_out_data !== 64'd3) begin bad++; $display("FAIL bp_hold_data got=%h want=3", m_out_data); end
    if (m_busy !== 1'b0) begin bad++; $display("FAIL bp_busy got=%b want=0", m_busy); end
    out_ready = 1;
    #1;
    total++;
    if (m_in_ready !== 1'b1) begin bad++; $display("FAIL bp_rise got=%b want=1", m_in_ready); end
    tick;
    din = 32'd4;
    total += 2;
    if (m_out_valid !== 1'b0) begin bad++; $display("FAIL bp_drain got=%b want=0", m_out_valid); end
    if (m_busy !== 1'b1) begin bad++; $display("FAIL bp_busy2 got=%b want=1", m_busy); end
    tick;
    in_valid = 0;
    total += 2;
    if (m_out_valid !== 1'b1) begin bad++; $display("FAIL bp_second_valid got=%b want=1", m_out_valid); end
    if (m_out_data[15:0] !== 16'd7) begin bad++; $display("FAIL bp_second got=%0d want=7", m_out_data[15:0]); end
    tick;
  endtask
  task automatic test_flush;
    len_cfg = 5'd1;
    out_ready = 0;
    din = 32'd9;
    in_valid = 1;
    tick;
    in_valid = 0;
    len_cfg = 5'd4;
    flush = 1;
    tick;
    flush = 0;
    total += 2;
    if (m_out_valid !== 1'b1) begin bad++; $display("FAIL fl_pending got=%b want=1", m_out_valid); end
    if (m_out_data[15:0] !== 16'd9) begin bad++; $display("FAIL fl_pending_data got=%0d want=9", m_out_data[15:0]); end
    out_ready = 1;
    din = 32'd1;
    in_valid = 1;
    tick;
    tick;
    total++;
    if (m_busy !== 1'b1) begin bad++; $display("FAIL fl_busy got=%b want=1", m_busy); end
    flush = 1;
    #1;
    total++;
    if (m_in_ready !== 1'b0) begin bad++; $display("FAIL fl_in_ready got=%b want=0", m_in_ready); end
    tick;
    flush = 0;
    total++;
    if (m_busy !== 1'b0) begin bad++; $display("FAIL fl_cleared got=%b want=0", m_busy); end
    for (int k = 0; k < 4; k++) tick;
    in_valid = 0;
    total += 2;
    if (m_out_valid !== 1'b1) begin bad++; $display("FAIL fl_valid got=%b want=1", m_out_valid); end
    if (m_out_data[15:0] !== 16'd4) begin bad++; $display("FAIL fl_sum got=%0d want=4", m_out_data[15:0]); end
    tick;
  endtask
  task automatic test_len;
    out_ready = 1;
    len_cfg = 5'd0;
    for (int k = 1; k <= 3; k++) begin
      din = 32'(k);
      in_valid = 1;
      tick;
      total++;
      if (m_out_valid !== 1'b1 || m_out_data[15:0] !== 16'(k))
        begin bad++; $display("FAIL len0 beat=%0d got=%b/%0d want=1/%0d", k, m_out_valid, m_out_data[15:0], k); end
    end
    len_cfg = 5'd20;
    din = 32'd1;
    for (int k = 1; k <= 16; k++) begin
      tick;
      if (k == 1) len_cfg = 5'd2;
      total++;
      if (k < 16) begin
        if (m_out_valid !== 1'b0) begin bad++; $display("FAIL lenmax_early beat=%0d got=%b want=0", k, m_out_valid); end
      end else if (m_out_valid !== 1'b1 || m_out_data[15:0] !== 16'd16)
        begin bad++; $display("FAIL lenmax_sum got=%b/%0d want=1/16", m_out_valid, m_out_data[15:0]); end
    end
    in_valid = 0;
    tick;
  endtask
  task automatic test_reset_mid;
    len_cfg = 5'd4;
    out_ready = 1;
    din = 32'd1;
    in_valid = 1;
    for (int k = 0; k < 3; k++) tick;
    in_valid = 0;
    total++;
    if (m_busy !== 1'b1) begin bad++; $display("FAIL rm_busy got=%b want=1", m_busy); end
    reset = 1;
    tick;
    total += 3;
    if (m_busy !== 1'b0) begin bad++; $display("FAIL rm_busy_clr got=%b want=0", m_busy); end
    if (m_in_ready !== 1'b0) begin bad++; $display("FAIL rm_in_ready got=%b want=0", m_in_ready); end
    if (m_out_valid !== 1'b0) begin bad++; $display("FAIL rm_valid got=%b want=0", m_out_valid); end
    reset = 0;
    len_cfg = 5'd1;
    out_ready = 0;
    din = 32'd7;
    in_valid = 1;
    tick;
    in_valid = 0;
    total++;
    if (m_out_valid !== 1'b1) begin bad++; $display("FAIL rm_pend got=%b want=1", m_out_valid); end
    reset = 1;
    tick;
    reset = 0;
    total += 2;
    if (m_out_valid !== 1'b0) begin bad++; $display("FAIL rm_pend_drop got=%b want=0", m_out_valid); end
    if (m_out_data !== 64'd0) begin bad++; $display("FAIL rm_data got=%h want=0", m_out_data); end
    out_ready = 1;
    len_cfg = 5'd4;
    din = 32'd2;
    in_valid = 1;
    for (int k = 0; k < 4; k++) tick;
    in_valid = 0;
    total += 2;
    if (m_out_valid !== 1'b1) begin bad++; $display("FAIL rm_fresh_valid got=%b want=1", m_out_valid); end
    if (m_out_data[15:0] !== 16'd8) begin bad++; $display("FAIL rm_fresh got=%0d want=8", m_out_data[15:0]); end
    tick;
  endtask
  initial begin
    test_reset;
    test_window;
    test_signed;
    test_backpressure;
    test_flush;
    test_len;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
